// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : serial_tx
//  Purpose  : Parallel-to-serial frame transmitter. A DATA_W-bit word is
//             accepted on a valid/ready handshake and sent as one start bit
//             (0), the data bits LSB first, an optional even-parity bit and
//             one stop bit (1). Each bit is held for CLKS_PER_BIT cycles.
//  Options  : `define PARITY_EN to insert an even-parity bit between the
//             last data bit and the stop bit.
//  Ports    : clk      - system clock, rising edge
//             rst_n    - asynchronous active-low reset
//             tx_data  - word to send, sampled only on acceptance
//             tx_valid - tx_data is valid
//             tx_ready - block can accept a word (IDLE only)
//             tx       - registered serial line, idles high
//             busy     - a frame is on the line
//             done     - one-cycle pulse in the first IDLE cycle after STOP
//  Revision : 1.0 - initial release
// ============================================================================
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int c_period_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_bit_w    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_period_w-1:0] c_period_last = c_period_w'(CLKS_PER_BIT - 1);
  localparam logic [c_bit_w-1:0]    c_bit_last    = c_bit_w'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_period_w-1:0] r_period;
  logic [c_period_w-1:0] w_period_nxt;
  logic [c_bit_w-1:0]    r_bit_cnt;
  logic [c_bit_w-1:0]    w_bit_cnt_nxt;
  logic [DATA_W-1:0]     r_shift;
  logic [DATA_W-1:0]     w_shift_nxt;
  logic [DATA_W-1:0]     w_shift_dn;
  logic                  r_tx;
  logic                  w_tx_nxt;
  logic                  r_done;
  logic                  w_done_nxt;
  logic                  w_period_end;
`ifdef PARITY_EN
  logic                  r_parity;
`endif

  assign w_period_end = (r_period == c_period_last);
  assign w_shift_dn   = r_shift >> 1;

  // tx is registered and loaded with the bit of the state being entered, so
  // the line only ever changes on a bit boundary.
  always_comb begin
    w_state_nxt   = r_state;
    w_period_nxt  = r_period;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_nxt = 1'b1;
        if (tx_valid) begin
          w_shift_nxt   = tx_data;
          w_period_nxt  = '0;
          w_bit_cnt_nxt = '0;
          w_tx_nxt      = 1'b0;
          w_state_nxt   = ST_START;
        end
      end
      ST_START: begin
        if (w_period_end) begin
          w_period_nxt = '0;
          w_tx_nxt     = r_shift[0];
          w_state_nxt  = ST_DATA;
        end else begin
          w_period_nxt = r_period + c_period_w'(1);
        end
      end
      ST_DATA: begin
        if (w_period_end) begin
          w_period_nxt = '0;
          if (r_bit_cnt == c_bit_last) begin
`ifdef PARITY_EN
            w_tx_nxt    = r_parity;
            w_state_nxt = ST_PARITY;
`else
            w_tx_nxt    = 1'b1;
            w_state_nxt = ST_STOP;
`endif
          end else begin
            w_shift_nxt   = w_shift_dn;
            w_bit_cnt_nxt = r_bit_cnt + c_bit_w'(1);
            w_tx_nxt      = w_shift_dn[0];
          end
        end else begin
          w_period_nxt = r_period + c_period_w'(1);
        end
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        if (w_period_end) begin
          w_period_nxt = '0;
          w_tx_nxt     = 1'b1;
          w_state_nxt  = ST_STOP;
        end else begin
          w_period_nxt = r_period + c_period_w'(1);
        end
      end
`endif
      ST_STOP: begin
        if (w_period_end) begin
          w_period_nxt = '0;
          w_tx_nxt     = 1'b1;
          w_done_nxt   = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_period_nxt = r_period + c_period_w'(1);
        end
      end
      default: begin
        w_period_nxt  = '0;
        w_bit_cnt_nxt = '0;
        w_tx_nxt      = 1'b1;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_period  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_period  <= w_period_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= w_tx_nxt;
      r_done    <= w_done_nxt;
    end
  end

`ifdef PARITY_EN
  // The shift register is consumed while sending, so parity of the accepted
  // word is captured once at acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (r_state == ST_IDLE && tx_valid) begin
      r_parity <= ^tx_data;
    end
  end
`endif

  assign tx       = r_tx;
  assign tx_ready = (r_state == ST_IDLE);
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_tx
//  Purpose  : Self-checking bench for serial_tx (DATA_W=8, CLKS_PER_BIT=4).
//             A frame-position model predicts tx/tx_ready/busy/done every
//             cycle; directed frames are also decoded and pinned to literals.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

  localparam int C = 4;
`ifdef PARITY_EN
  localparam int NB = 11;
  localparam logic [NB-1:0] c_exp_a5 = 11'b10101001010;
  localparam logic [NB-1:0] c_exp_01 = 11'b11000000010;
  localparam logic [NB-1:0] c_exp_3c = 11'b10001111000;
  localparam logic [NB-1:0] c_exp_00 = 11'b10000000000;
  localparam logic [NB-1:0] c_exp_ff = 11'b10111111110;
  localparam int c_exp_done = 45;
  localparam int c_exp_busy = 44;
`else
  localparam int NB = 10;
  localparam logic [NB-1:0] c_exp_a5 = 10'b1101001010;
  localparam logic [NB-1:0] c_exp_01 = 10'b1000000010;
  localparam logic [NB-1:0] c_exp_3c = 10'b1001111000;
  localparam logic [NB-1:0] c_exp_00 = 10'b1000000000;
  localparam logic [NB-1:0] c_exp_ff = 10'b1111111110;
  localparam int c_exp_done = 41;
  localparam int c_exp_busy = 40;
`endif
  localparam int FL = NB * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy, done;

  int checks = 0;
  int errors = 0;

  // model state
  int         cyc = 0;
  int         pos = 0;
  logic [7:0] m_word = 8'h00;
  logic       m_done = 1'b0;
  int         acc_cnt = 0;
  int         acc_times[$];

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected line level at frame position p (0 = idle, 1..FL in frame).
  function automatic logic exp_line(input int p, input logic [7:0] w);
    int idx;
    if (p == 0) return 1'b1;
    idx = (p - 1) / C;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return w[idx-1];
`ifdef PARITY_EN
    if (idx == 9) return ^w;
`endif
    return 1'b1;
  endfunction

  // Model update on each edge, then compare just after the edge.
  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    if (!rst_n) begin
      pos = 0;
    end else if (pos == 0) begin
      if (tx_valid) begin
        pos = 1;
        m_word = tx_data;
        acc_cnt++;
        acc_times.push_back(cyc);
      end
    end else if (pos == FL) begin
      pos = 0;
      m_done = 1'b1;
    end else begin
      pos++;
    end
    #1;
    check("tx", int'(tx), int'(exp_line(pos, m_word)));
    check("tx_ready", int'(tx_ready), int'(pos == 0));
    check("busy", int'(busy), int'(pos != 0));
    check("done", int'(done), int'(m_done));
  end

  task automatic send_capture(input logic [7:0] w, input bit disturb,
                              output logic [NB-1:0] bits, output int done_at,
                              output int busy_cycles);
    @(negedge clk);
    tx_data  = w;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid    = 1'b0;
    bits        = '0;
    done_at     = 0;
    busy_cycles = 0;
    for (int n = 1; n <= FL + 8; n++) begin
      if (((n - 1) % C) == 1 && ((n - 1) / C) < NB) bits[(n-1)/C] = tx;
      if (busy) busy_cycles++;
      if (done && done_at == 0) done_at = n;
      if (disturb && n == 10) begin
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
      end
      if (disturb && n == 11) tx_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
  endtask

  task automatic wait_acc(input int target, input string name);
    int k = 0;
    while (acc_cnt < target && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (acc_cnt < target) check(name, acc_cnt, target);
  endtask

  initial begin
    logic [NB-1:0] bits;
    int done_at, busy_cycles, a0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // single frame 0xA5
    send_capture(8'hA5, 1'b0, bits, done_at, busy_cycles);
    check("frame_a5", int'(bits), int'(c_exp_a5));
    check("done_cycle", done_at, c_exp_done);
    check("busy_cycles", busy_cycles, c_exp_busy);

    send_capture(8'h01, 1'b0, bits, done_at, busy_cycles);
    check("frame_01", int'(bits), int'(c_exp_01));

    // data/valid disturbance during the frame must be ignored
    a0 = acc_cnt;
    send_capture(8'h3C, 1'b1, bits, done_at, busy_cycles);
    check("frame_3c", int'(bits), int'(c_exp_3c));
    check("accepts_3c", acc_cnt - a0, 1);

    send_capture(8'h00, 1'b0, bits, done_at, busy_cycles);
    check("frame_00", int'(bits), int'(c_exp_00));
    send_capture(8'hFF, 1'b0, bits, done_at, busy_cycles);
    check("frame_ff", int'(bits), int'(c_exp_ff));
    check("done_cycle_ff", done_at, c_exp_done);

    // back-to-back with tx_valid held high
    idle_cycles(2);
    a0 = acc_cnt;
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    wait_acc(a0 + 1, "b2b_first_accept");
    @(negedge clk);
    tx_data = 8'hFF;
    wait_acc(a0 + 2, "b2b_second_accept");
    tx_valid = 1'b0;
    if (acc_cnt >= a0 + 2)
      check("b2b_spacing", acc_times[a0+1] - acc_times[a0], c_exp_done);
    idle_cycles(FL + 5);

    // asynchronous reset at cycle 10 of a frame
    @(negedge clk);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_tx", int'(tx), 1);
    check("rst_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(FL + 5);
    send_capture(8'hA5, 1'b0, bits, done_at, busy_cycles);
    check("frame_after_rst", int'(bits), int'(c_exp_a5));

    // randomized traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom);
    end
    idle_cycles(FL + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
